// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

  // Width of a counter that must hold the values 0 .. hold_cycles.
  function automatic int hold_cnt_w(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage : rst_seq_pkg

// File: rtl/rst_sequencer_sva.sv
// Pure checker for the reset sequencer outputs. It is only instantiated by
// rst_sequencer when RST_SEQ_SVA_EN is defined.
module rst_sequencer_sva #(
  parameter int HOLD_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  input logic req,
  input logic rst_out,
  input logic rst_done
);

  // Once released, reset stays low on every following cycle until a request
  // is sampled; each step re-enters the property one cycle later.
  property p_stay_low;
    !req |=> (!rst_out and p_stay_low);
  endproperty

  a_stay_low: assert property (@(posedge clk) disable iff (rst)
    $fell(rst_out) |-> p_stay_low)
    $info("%t: a_stay_low pass", $time);
    else $error("%t: a_stay_low violated", $time);

  a_done_on_fall: assert property (@(posedge clk) disable iff (rst)
    rst_done |-> $fell(rst_out))
    $info("%t: a_done_on_fall pass", $time);
    else $error("%t: a_done_on_fall violated", $time);

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    rst_done |=> !rst_done)
    $info("%t: a_done_single pass", $time);
    else $error("%t: a_done_single violated", $time);

  a_min_hold: assert property (@(posedge clk) disable iff (rst)
    $rose(rst_out) |-> rst_out [*HOLD_CYCLES])
    $info("%t: a_min_hold pass", $time);
    else $error("%t: a_min_hold violated", $time);

endmodule : rst_sequencer_sva

// File: rtl/rst_sequencer.sv
// Reset sequencer: stretches raw reset and software reset requests into a
// clean, fixed-length synchronous reset for downstream logic, pulses
// rst_done on release and counts completed sequences (saturating).
// Optional macro RST_SEQ_SVA_EN instantiates the rst_sequencer_sva checker.
//
// Handshake note: there is no valid/ready pairing here; req is a plain level
// sampled every rising edge, and every output is taken straight from a flop.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             rst_out,
  output logic             rst_done,
  output logic             busy,
  output logic [CNT_W-1:0] rst_count,
  output rst_state_t       state_dbg_o
);

  localparam int HC_W = hold_cnt_w(HOLD_CYCLES);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("rst_sequencer: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  rst_state_t       state_q, state_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, hold counter, release pulse and sequence counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a request restarts the hold, otherwise HOLD counts up
  // and releases on its last cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD: begin
        if (req) begin
          hcnt_d = '0;
        end else if (hcnt_q == HC_LAST) begin
          state_d = RUN;
          hcnt_d  = '0;
          done_d  = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = HOLD;
        hcnt_d  = '0;
      end
    endcase
  end

  assign rst_out     = (state_q == HOLD);
  assign busy        = (state_q == HOLD);
  assign rst_done    = done_q;
  assign rst_count   = cnt_q;
  assign state_dbg_o = state_q;

`ifdef RST_SEQ_SVA_EN
  rst_sequencer_sva #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_sva (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rst_out (rst_out),
    .rst_done(rst_done)
  );
`else
`endif

endmodule : rst_sequencer
